// File: rtl/data_mem_resp.sv
// Data-memory responder for the core's load/store port.
// Fixed-latency word store with byte-lane writes.
module data_mem_resp #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        data_ok,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] LP_CNT0 =
    (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [3:0]          r_sel;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_data_ok;
  logic [31:0]         r_mem [2**ADDR_W];

  logic [ADDR_W-1:0]   w_idx;
  logic                w_unused_addr;

  assign w_idx = addr[ADDR_W+1:2];
  assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_rdata   <= 32'h0;
      r_data_ok <= 1'b0;
    end else begin
      r_data_ok <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (mem_en) begin
            r_we    <= mem_we;
            r_sel   <= sel;
            r_idx   <= w_idx;
            r_wdata <= wdata;
            if (WAIT_CYC == 0) begin
              r_state   <= S_RESP;
              r_data_ok <= 1'b1;
              if (!mem_we)
                r_rdata <= r_mem[w_idx];
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LP_CNT0;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state   <= S_RESP;
            r_data_ok <= 1'b1;
            if (!r_we)
              r_rdata <= r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Commit on the edge leaving RESP; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (rst && r_state == S_RESP && r_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_sel[i])
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign rdata   = r_rdata;
  assign data_ok = r_data_ok;
  assign stall   = rst & (((r_state == S_IDLE) & mem_en) |
                          (r_state == S_WAIT));

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter ADDR_W, 10, word-address width; storage is 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYC, 2, wait states per access; legal range 0..15.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-low; sampled only on rising clk.
REQ-005 mem_en  in  1  core data request valid; held stable by the core while stall=1.
REQ-006 mem_we  in  1  1 = write, 0 = read.
REQ-007 sel  in  4  byte-lane select; bit i covers wdata[8i+7:8i].
REQ-008 addr  in  32  byte address; word index is addr[ADDR_W+1:2].
REQ-009 wdata  in  32  write data, lane-aligned.
REQ-010 rdata  out  32  registered read data; full word returned regardless of sel.
REQ-011 data_ok  out  1  one-cycle pulse marking completion of the accepted access.
REQ-012 stall  out  1  core pipeline hold request.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP, with a 4-bit wait counter.
REQ-014 In IDLE with mem_en=1, the block SHALL accept the request and capture mem_we, sel, word index and wdata.
- Next state is WAIT with counter=WAIT_CYC-1, or RESP if WAIT_CYC=0.
REQ-015 In WAIT, the counter SHALL decrement each cycle; at 0, the next state SHALL be RESP.
REQ-016 RESP SHALL last exactly one cycle, SHALL assert data_ok=1, and SHALL return to IDLE unconditionally.
REQ-017 stall SHALL be combinational: 1 when (IDLE and mem_en=1) or WAIT; 0 in RESP and in idle IDLE.
REQ-018 Access latency SHALL be fixed: a request accepted in cycle T SHALL complete with data_ok in cycle T+1+WAIT_CYC.
REQ-019 Writes SHALL commit on the clock edge that ends the RESP cycle.
- Only lanes with sel=1 are written.
- sel=0000 is a no-op but still completes the handshake.
REQ-020 For reads, rdata SHALL be loaded on the edge entering RESP and held until the next read completes.
- Writes leave rdata unchanged.
REQ-021 mem_en SHALL be ignored in WAIT and RESP.
- The request held during RESP is not re-accepted.
- A new request is accepted no earlier than the cycle after RESP.
REQ-022 If mem_en deasserts after acceptance (for example, a flush), the accepted access SHALL still complete, including any write.
REQ-023 Address bits above ADDR_W+1 and addr[1:0] SHALL be ignored; addresses alias modulo 2^(ADDR_W+2).
REQ-024 A read immediately after a write to the same word SHALL return the newly written data.

Reset
REQ-025 When rst=0 at a rising edge, the block SHALL:
- Set state to IDLE and the counter to 0.
- Set rdata to 0x00000000 and data_ok to 0.
- Force stall to 0 while rst=0.
REQ-026 Reset during WAIT or RESP SHALL abandon the access; a pending write SHALL NOT be committed.
REQ-027 Storage contents SHALL NOT be cleared by reset.

Verification (WAIT_CYC=2 unless stated)
REQ-028 Write 0x12345678 to addr 0x10 with sel=1111, mem_we=1 at T -> stall=1 in T..T+2, data_ok=1 at T+3; a following read of 0x10 returns rdata=0x12345678 with its data_ok.
REQ-029 Write 0x0000AB00 to addr 0x10 with sel=0010 -> a subsequent read of 0x10 returns 0x1234AB78.
REQ-030 Back-to-back reads of 0x10 and 0x14 with mem_en held high -> each completes in 4 cycles (3 stall cycles, one RESP cycle with stall=0), with no duplicate acceptance in RESP.
REQ-031 Write 0xFFFFFFFF to addr 0x20 (previously 0x0), with rst=0 asserted in its WAIT state -> outputs return to reset values next cycle; a later read of 0x20 returns 0x00000000.
REQ-032 WAIT_CYC=0 and a read accepted at T -> stall=1 only in T, data_ok=1 at T+1.
REQ-033 ADDR_W=10: write 0xCAFEF00D to addr 0x1010 -> a read of addr 0x10 returns 0xCAFEF00D.
